// File: rtl/sec_sched_pkg.sv
// Shared definitions for the seconds-tick timer scheduler: FSM encoding and
// default channel geometry.
package sec_sched_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/N_bit_counter.sv
// Combinational N-bit up/down step: the shared arithmetic unit of the sweep.
module N_bit_counter #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_val,
    input  logic         i_up,
    output logic [N-1:0] o_val
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Single adder/subtractor selected by direction.
    always_comb begin
        if (i_up) begin
            o_val = i_val + ONE;
        end else begin
            o_val = i_val - ONE;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found scanning
// upward (with wrap) from the pointer position.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    logic [2*N-1:0] req_dbl_s;
    logic [2*N-1:0] gnt_dbl_s;
    logic [N-1:0]   req_rot_s;
    logic [N-1:0]   gnt_rot_s;

    // Rotate so the pointer lands on bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl_s = {i_req, i_req} >> i_ptr;
        req_rot_s = req_dbl_s[N-1:0];
        gnt_rot_s = req_rot_s & (~req_rot_s + {{(N-1){1'b0}}, 1'b1});
        gnt_dbl_s = {gnt_rot_s, gnt_rot_s} << i_ptr;
        o_grant   = gnt_dbl_s[2*N-1:N];
    end

endmodule

// File: rtl/sec_tick_timer_scheduler.sv
// Seconds-tick timer scheduler: N_CH countdown channels share one decrementer.
// A rising edge of the 1 Hz square wave queues a sweep; the sweep visits one
// channel per cycle. Loads are arbitrated round-robin only while idle.
module sec_tick_timer_scheduler
    import sec_sched_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sec_tick,
    input  logic [N_CH-1:0]       i_load_req,
    input  logic [N_CH*CNT_W-1:0] i_load_val,
    input  logic [N_CH-1:0]       i_cancel,
    output logic [N_CH-1:0]       o_load_ack,
    output logic [N_CH-1:0]       o_busy,
    output logic [N_CH-1:0]       o_expired,
    output logic                  o_sweep
);

    localparam int IDX_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   tick_prev_q, tick_prev_d;
    logic                   tick_pend_q, tick_pend_d;
    logic [N_CH-1:0]        busy_q, busy_d;
    logic [N_CH-1:0]        expired_q, expired_d;
    logic [CNT_W-1:0]       cnt_q [N_CH];
    logic [CNT_W-1:0]       cnt_d [N_CH];

    logic                   tick_edge_s;
    logic                   grant_en_s;
    logic [N_CH-1:0]        arb_req_s;
    logic [N_CH-1:0]        grant_s;
    logic [CNT_W-1:0]       dec_in_s;
    logic [CNT_W-1:0]       dec_out_s;

    // Edge detect and arbiter gating: cancel masks a same-cycle load request.
    always_comb begin
        tick_edge_s = i_sec_tick & ~tick_prev_q;
        grant_en_s  = (state_q == S_IDLE) & ~tick_pend_q;
        if (grant_en_s) begin
            arb_req_s = i_load_req & ~i_cancel;
        end else begin
            arb_req_s = '0;
        end
        dec_in_s = cnt_q[idx_q];
    end

    rr_arbiter #(.N(N_CH), .PW(IDX_W)) u_arb (
        .i_req   (arb_req_s),
        .i_ptr   (ptr_q),
        .o_grant (grant_s)
    );

    N_bit_counter #(.N(CNT_W)) u_dec (
        .i_val (dec_in_s),
        .i_up  (1'b0),
        .o_val (dec_out_s)
    );

    // Next-state: FSM, load grants, sweep decrement/expiry, then cancel override.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        tick_prev_d = i_sec_tick;
        tick_pend_d = tick_pend_q;
        busy_d      = busy_q;
        expired_d   = '0;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (tick_pend_q) begin
                    state_d     = S_SWEEP;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                end else begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (grant_s[k]) begin
                            cnt_d[k]  = i_load_val[k*CNT_W +: CNT_W];
                            busy_d[k] = 1'b1;
                            ptr_d     = (k == N_CH - 1) ? '0 : IDX_W'(k + 1);
                        end else begin
                            busy_d[k] = busy_d[k];
                        end
                    end
                end
            end
            S_SWEEP: begin
                if (busy_q[idx_q]) begin
                    if (cnt_q[idx_q] > CNT_ONE) begin
                        cnt_d[idx_q] = dec_out_s;
                    end else begin
                        cnt_d[idx_q]     = '0;
                        busy_d[idx_q]    = 1'b0;
                        expired_d[idx_q] = 1'b1;
                    end
                end else begin
                    cnt_d[idx_q] = cnt_q[idx_q];
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        if (tick_edge_s) begin
            tick_pend_d = 1'b1;
        end else begin
            tick_pend_d = tick_pend_d;
        end

        busy_d    = busy_d & ~i_cancel;
        expired_d = expired_d & ~i_cancel;
    end

    // State registers with synchronous reset; reset mid-sweep drops all expiries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ptr_q       <= '0;
            tick_prev_q <= 1'b0;
            tick_pend_q <= 1'b0;
            busy_q      <= '0;
            expired_q   <= '0;
            cnt_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            tick_prev_q <= tick_prev_d;
            tick_pend_q <= tick_pend_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
            cnt_q       <= cnt_d;
        end
    end

    // Ack is same-cycle with the capture; the rest come straight from flops.
    always_comb begin
        o_load_ack = grant_s;
        o_busy     = busy_q;
        o_expired  = expired_q;
        o_sweep    = (state_q == S_SWEEP);
    end

endmodule
